// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Optional build macro used by fifo_wr_arb: FIFO_WR_ARB_TAG_EN (source tag in wdata MSBs).
package fifo_pkg;

   localparam int unsigned BEAT_W = 8;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_t;

   // First set bit of req searching ptr+1, ptr+2, ... modulo n (n <= 8); returns ptr if none set.
   function automatic logic [2:0] rr_next(input logic [7:0] req,
                                          input logic [2:0] ptr,
                                          input int unsigned n);
      logic [2:0]  sel;
      logic        hit;
      int unsigned cand;
      sel = ptr;
      hit = 1'b0;
      for (int unsigned k = 1; k <= 8; k++) begin
         cand = (32'(ptr) + k) % n;
         if (!hit && (k <= n) && req[cand[2:0]]) begin
            sel = cand[2:0];
            hit = 1'b1;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational rotate-priority encoder: request vector + last-grant pointer -> next index.
module rr_pick
   import fifo_pkg::*;
#(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned ID_WIDTH = 2
) (
   input  logic [NUM_REQ-1:0]  i_req,
   input  logic [ID_WIDTH-1:0] i_ptr,
   output logic [ID_WIDTH-1:0] o_idx,
   output logic                o_found
);

   always_comb begin
      o_found = |i_req;
      o_idx   = ID_WIDTH'(rr_next(8'(i_req), 3'(i_ptr), NUM_REQ));
   end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter sharing the async FIFO write port between NUM_REQ producers.
// Build option: define FIFO_WR_ARB_TAG_EN to replace the top ID_WIDTH bits of wdata with grant_id.
module fifo_wr_arb
   import fifo_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_BURST  = 8,
   parameter int unsigned ID_WIDTH   = 2
) (
   input  logic                          wclk,
   input  logic                          sys_rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          wfull,
   output logic                          winc,
   output logic [DATA_WIDTH-1:0]         wdata,
   output logic [ID_WIDTH-1:0]           grant_id,
   output logic                          busy
);

   arb_state_t          r_state;
   arb_state_t          w_state_nxt;
   logic [ID_WIDTH-1:0] r_rr_ptr;
   logic [ID_WIDTH-1:0] w_rr_ptr_nxt;
   logic [ID_WIDTH-1:0] r_grant_id;
   logic [ID_WIDTH-1:0] w_grant_id_nxt;
   logic [BEAT_W-1:0]   r_beat_cnt;
   logic [BEAT_W-1:0]   w_beat_cnt_nxt;

   logic [ID_WIDTH-1:0]   w_pick_idx;
   logic                  w_pick_found;
   logic                  w_sel_valid;
   logic [DATA_WIDTH-1:0] w_sel_data;

   rr_pick #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_rr_pick (
      .i_req   (req_valid),
      .i_ptr   (r_rr_ptr),
      .o_idx   (w_pick_idx),
      .o_found (w_pick_found)
   );

   assign w_sel_valid = req_valid[r_grant_id];
   assign w_sel_data  = req_data[32'(r_grant_id)*DATA_WIDTH +: DATA_WIDTH];

`ifdef FIFO_WR_ARB_TAG_EN
   assign wdata = {r_grant_id, w_sel_data[DATA_WIDTH-ID_WIDTH-1:0]};
`else
   assign wdata = w_sel_data;
`endif

   assign grant_id = r_grant_id;
   assign busy     = (r_state == ARB_BURST);

   always_ff @(posedge wclk) begin
      if (sys_rst) begin
         r_state    <= ARB_IDLE;
         r_rr_ptr   <= ID_WIDTH'(NUM_REQ - 1);
         r_grant_id <= '0;
         r_beat_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_rr_ptr   <= w_rr_ptr_nxt;
         r_grant_id <= w_grant_id_nxt;
         r_beat_cnt <= w_beat_cnt_nxt;
      end
   end

   // Next-state, handshake and write strobe; wfull stalls hold the grant without counting.
   always_comb begin
      w_state_nxt    = r_state;
      w_rr_ptr_nxt   = r_rr_ptr;
      w_grant_id_nxt = r_grant_id;
      w_beat_cnt_nxt = r_beat_cnt;
      req_ready      = '0;
      winc           = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (w_pick_found) begin
               w_grant_id_nxt = w_pick_idx;
               w_rr_ptr_nxt   = w_pick_idx;
               w_beat_cnt_nxt = '0;
               w_state_nxt    = ARB_BURST;
            end
         end
         ARB_BURST: begin
            if (!w_sel_valid) begin
               w_state_nxt = ARB_IDLE;
            end else begin
               req_ready[r_grant_id] = ~wfull;
               if (!wfull) begin
                  winc           = 1'b1;
                  w_beat_cnt_nxt = r_beat_cnt + BEAT_W'(1);
                  if (w_beat_cnt_nxt == BEAT_W'(MAX_BURST)) begin
                     w_state_nxt = ARB_IDLE;
                  end
               end
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
      if (sys_rst) begin
         req_ready = '0;
         winc      = 1'b0;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: directed table, hand sequences and random traffic vs. a reference model.
module tb_fifo_wr_arb;

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned MB = 8;
   localparam int unsigned IW = 2;

   logic            wclk = 1'b0;
   logic            sys_rst;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            wfull;
   logic            winc;
   logic [DW-1:0]   wdata;
   logic [IW-1:0]   grant_id;
   logic            busy;

   always #5 wclk = ~wclk;

   fifo_wr_arb #(
      .NUM_REQ    (N),
      .DATA_WIDTH (DW),
      .MAX_BURST  (MB),
      .ID_WIDTH   (IW)
   ) dut (
      .wclk      (wclk),
      .sys_rst   (sys_rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .wfull     (wfull),
      .winc      (winc),
      .wdata     (wdata),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   int n_checks;
   int n_errors;

   logic [31:0] cnt [N];
   logic [31:0] ovr [N];
   logic        use_ovr;

   // Reference model: owner of the write port (-1 = arbitrating), last winner, words in this grant.
   int m_owner;
   int m_last;
   int m_beats;
   int m_gid;

   logic [31:0] got_q[$];
   int          grant_log[$];
   logic        prev_busy;

   typedef struct {
      logic [N-1:0] v;
      logic         full;
      logic [N-1:0] exp_ready;
      logic         exp_winc;
      int           exp_gid;
      logic         exp_busy;
   } vec_t;

   vec_t tbl [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] src_word(input int i);
      if (use_ovr) return ovr[i];
      return (32'(i) << 8) | cnt[i];
   endfunction

   function automatic logic [31:0] fifo_word(input int g, input logic [31:0] d);
      logic [31:0] w;
      w = d;
`ifdef FIFO_WR_ARB_TAG_EN
      w[31:30] = 2'(g);
`else
      if (g < 0) w = d;
`endif
      return w;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_last  = N - 1;
      m_beats = 0;
      m_gid   = 0;
   endtask

   // One clock cycle: drive at negedge, compare 1ns later, advance the model.
   task automatic step(input logic [N-1:0] v, input logic full, input logic rst);
      logic [N-1:0] e_ready;
      logic         e_winc;
      logic [31:0]  e_data;
      logic         e_busy;
      int           e_gid;
      logic         found;
      int           c;
      @(negedge wclk);
      req_valid = v;
      wfull     = full;
      sys_rst   = rst;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = src_word(i);
      #1;
      e_ready = '0;
      e_winc  = 1'b0;
      e_data  = '0;
      e_busy  = (m_owner >= 0);
      e_gid   = m_gid;
      if (rst) begin
         model_reset();
      end else if (m_owner < 0) begin
         found = 1'b0;
         for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (!found && v[c]) begin
               found   = 1'b1;
               m_owner = c;
               m_last  = c;
               m_gid   = c;
               m_beats = 0;
            end
         end
      end else if (!v[m_owner]) begin
         m_owner = -1;
      end else if (!full) begin
         e_ready[m_owner] = 1'b1;
         e_winc           = 1'b1;
         e_data           = fifo_word(m_owner, src_word(m_owner));
         cnt[m_owner]     = cnt[m_owner] + 32'd1;
         m_beats++;
         if (m_beats == MB) m_owner = -1;
      end
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("winc", 32'(winc), 32'(e_winc));
      if (e_winc) chk("wdata", wdata, e_data);
      chk("grant_id", 32'(grant_id), 32'(e_gid));
      chk("busy", 32'(busy), 32'(e_busy));
      if (winc) got_q.push_back(wdata);
      if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
      prev_busy = busy;
   endtask

   task automatic do_reset();
      step('0, 1'b0, 1'b1);
      for (int i = 0; i < N; i++) cnt[i] = '0;
      got_q.delete();
      grant_log.delete();
      prev_busy = 1'b0;
   endtask

   initial begin
      logic [N-1:0] rv;
      logic [31:0]  tag_exp;
      n_checks  = 0;
      n_errors  = 0;
      use_ovr   = 1'b0;
      prev_busy = 1'b0;
      for (int i = 0; i < N; i++) begin
         cnt[i] = '0;
         ovr[i] = '0;
      end
      sys_rst   = 1'b1;
      req_valid = '0;
      wfull     = 1'b0;
      req_data  = '0;
      model_reset();

      //               v        full  ready    winc  gid busy
      tbl[0]  = '{4'b0100, 1'b0, 4'b0000, 1'b0, 0, 1'b0};
      tbl[1]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2, 1'b1};
      tbl[2]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2, 1'b1};
      tbl[3]  = '{4'b0100, 1'b1, 4'b0000, 1'b0, 2, 1'b1};
      tbl[4]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2, 1'b1};
      tbl[5]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2, 1'b1};
      tbl[6]  = '{4'b0100, 1'b0, 4'b0000, 1'b0, 2, 1'b0};
      tbl[7]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2, 1'b1};
      tbl[8]  = '{4'b0011, 1'b0, 4'b0000, 1'b0, 2, 1'b1};
      tbl[9]  = '{4'b0011, 1'b0, 4'b0000, 1'b0, 2, 1'b0};
      tbl[10] = '{4'b0011, 1'b0, 4'b0001, 1'b1, 0, 1'b1};

      repeat (2) @(posedge wclk);

      for (int r = 0; r < 11; r++) begin
         step(tbl[r].v, tbl[r].full, 1'b0);
         chk("tbl_ready", 32'(req_ready), 32'(tbl[r].exp_ready));
         chk("tbl_winc", 32'(winc), 32'(tbl[r].exp_winc));
         chk("tbl_gid", 32'(grant_id), 32'(tbl[r].exp_gid));
         chk("tbl_busy", 32'(busy), 32'(tbl[r].exp_busy));
      end

      // All requesters busy: grant order 0,1,2,3,0 with 8-word bursts.
      do_reset();
      repeat (46) step(4'hF, 1'b0, 1'b0);
      chk("rr_grant_count", 32'(grant_log.size()), 32'd5);
      if (grant_log.size() >= 5) begin
         chk("rr_order0", 32'(grant_log[0]), 32'd0);
         chk("rr_order1", 32'(grant_log[1]), 32'd1);
         chk("rr_order2", 32'(grant_log[2]), 32'd2);
         chk("rr_order3", 32'(grant_log[3]), 32'd3);
         chk("rr_order4", 32'(grant_log[4]), 32'd0);
      end
      chk("rr_word_count", 32'(got_q.size()), 32'd40);
      if (got_q.size() >= 8)
         for (int i = 0; i < 8; i++) chk("first_burst_word", got_q[i], fifo_word(0, 32'(i)));

      // wfull stall of 5 cycles after word 4 of requester 1.
      do_reset();
      step(4'b0010, 1'b0, 1'b0);
      repeat (4) step(4'b0010, 1'b0, 1'b0);
      repeat (5) begin
         step(4'b0010, 1'b1, 1'b0);
         chk("stall_ready", 32'(req_ready[1]), 32'd0);
      end
      repeat (4) step(4'b0010, 1'b0, 1'b0);
      step(4'b0010, 1'b0, 1'b0);
      chk("stall_idle_after", 32'(busy), 32'd0);
      chk("stall_word_count", 32'(got_q.size()), 32'd8);
      if (got_q.size() == 8)
         for (int i = 0; i < 8; i++) chk("stall_word", got_q[i], fifo_word(1, 32'h100 + 32'(i)));

      // Reset pulse mid-burst with three words already written.
      do_reset();
      step(4'hF, 1'b0, 1'b0);
      repeat (3) step(4'hF, 1'b0, 1'b0);
      step(4'hF, 1'b0, 1'b1);
      chk("rst_mid_winc", 32'(winc), 32'd0);
      step(4'hF, 1'b0, 1'b0);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_winc", 32'(winc), 32'd0);
      chk("post_rst_gid", 32'(grant_id), 32'd0);
      step(4'hF, 1'b0, 1'b0);
      chk("post_rst_regrant", 32'(grant_id), 32'd0);
      chk("post_rst_busy2", 32'(busy), 32'd1);

      // Random traffic against the model.
      do_reset();
      for (int t = 0; t < 3000; t++) begin
         rv = N'($urandom) | N'($urandom);
         step(rv, ($urandom_range(0, 3) == 0), ($urandom_range(0, 255) == 0));
      end

      // Source tag on requester 3.
      use_ovr = 1'b1;
      ovr[3]  = 32'h0000_00AA;
      do_reset();
      step(4'b1000, 1'b0, 1'b0);
      step(4'b1000, 1'b0, 1'b0);
`ifdef FIFO_WR_ARB_TAG_EN
      tag_exp = 32'hC000_00AA;
`else
      tag_exp = 32'h0000_00AA;
`endif
      chk("tag_winc", 32'(winc), 32'd1);
      chk("tag_wdata", wdata, tag_exp);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
